led_chaser: RTL and testbench
=============================

// Module: led_chaser
// PURPOSE
//   Parametrised LED sequencer; successor to the fixed 4-LED, 12.5M-cycle chaser.
//   Drives NUM_LEDS one-hot outputs and steps on a programmable tick.
//   Runtime modes: rotate-up, rotate-down, ping-pong, hold.
//   Top-level board block; sits between the board clock/reset and the LED pins.
// PARAMETERS
//   NUM_LEDS     4           number of LED outputs, >=1
//   TICK_CYCLES  12_500_000  clk cycles per step (0.25 s at 50 MHz), >=1
//   CNT_W        25          prescaler width; must satisfy 2**CNT_W >= TICK_CYCLES
//   IDX_W        2           index width; must satisfy 2**IDX_W >= NUM_LEDS; min 1
// PORTS
//   clk         in   1         system clock, 50 MHz
//   rst         in   1         asynchronous reset, active-low
//   en          in   1         1 = run prescaler and stepping; 0 = freeze all state
//   mode        in   2         00 rot-up, 01 rot-down, 10 ping-pong, 11 hold
//   led         out  NUM_LEDS  one-hot LED drive, 1 = lit
//   led_idx     out  IDX_W     index of the lit LED
//   step_pulse  out  1         1-cycle strobe coincident with each new led_idx
//   duty        in   8         PWM duty (only with LED_CHASER_PWM_EN)
// BEHAVIOUR
//   Reset (rst=0, async):
//     cnt=0; led_idx=0; led={..,1}; dir=up; step_pulse=0.
//   Prescaler:
//     - en=1: cnt increments each cycle; when cnt==TICK_CYCLES-1, cnt -> 0 and tick=1 that cycle.
//     - en=0: cnt holds, no tick. en dropping in the tick cycle suppresses that step.
//     - TICK_CYCLES=1: tick every enabled cycle.
//   Step, at the clock edge closing a tick cycle:
//     - rot-up: idx -> (idx==NUM_LEDS-1) ? 0 : idx+1; dir <= up.
//     - rot-down: idx -> (idx==0) ? NUM_LEDS-1 : idx-1; dir <= down.
//     - ping-pong: move one step in dir. At idx==NUM_LEDS-1 going up, go to NUM_LEDS-2 and set dir=down.
//       At idx==0 going down, go to 1 and set dir=up. No dwell at the ends.
//     - hold: idx and dir unchanged; step_pulse stays 0; prescaler keeps running.
//     - NUM_LEDS=1: idx is always 0; step_pulse still fires in non-hold modes.
//   Mode changes are sampled only in tick cycles; a change mid-period takes effect at the next tick.
//   Outputs:
//     - led_idx is registered; led = 1<<led_idx, decoded from the register (glitch-free, same edge).
//     - step_pulse is registered: high for exactly the cycle after the updating edge.
//   Invariants: led is never all-zero or multi-hot; led_idx < NUM_LEDS always.
// CONFIGURATION
//   LED_CHASER_PWM_EN defined:
//     - duty port and a free-running 8-bit pwm_cnt (reset 0, wraps 255->0) are present.
//     - led = onehot & {NUM_LEDS{pwm_cnt < duty}}.
//     - duty=0: all dark. duty=255: lit 255/256 of the time. led_idx and step_pulse are unaffected.
//     - pwm_cnt runs regardless of en.
//   LED_CHASER_PWM_EN undefined:
//     - no duty port, no pwm_cnt; led is the plain one-hot.
// STRUCTURE
//   led_chaser_pkg:
//     - mode localparams MODE_ROT_UP=2'b00, MODE_ROT_DN=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11.
//     - DIR_UP=1'b0, DIR_DN=1'b1.
//   Sub-module led_prescaler (params TICK_CYCLES, CNT_W; ports clk, rst, en, tick).
//   Index/direction update and one-hot decode stay in led_chaser.
// TESTING (TICK_CYCLES=4, NUM_LEDS=4 unless stated)
//   - Reset/async: assert rst mid-period with led=0100 -> led=0001 and idx=0 before the next edge.
//     Then the first step_pulse comes 4 cycles after release.
//   - Rot-up wrap: mode=00, en=1 for 20 cycles -> led 0001,0010,0100,1000,0001.
//     One step_pulse per 4 cycles.
//   - Ping-pong: mode=10 from idx 0 -> idx 1,2,3,2,1,0,1. NUM_LEDS=1 run: idx stays 0.
//   - en/hold: en=0 for 10 cycles mid-period -> cnt, idx frozen, then period resumes with the remaining count.
//     mode=11 -> no steps, no step_pulse.
//   - Mode switch: rot-up at idx 2 -> set mode=01 one cycle after a tick -> next step is idx 1.
//     Ping-pong then resumes in dir=down.
//   - PWM (macro on): duty=64 -> lit LED high exactly 64 of every 256 cycles.
//     duty=0 -> led=0 throughout, while idx still steps.

Source files
------------

// File: rtl/led_chaser_pkg.sv
// Shared constants for the LED chaser: mode encodings and ping-pong direction.
package led_chaser_pkg;

  localparam logic [1:0] MODE_ROT_UP   = 2'b00;
  localparam logic [1:0] MODE_ROT_DN   = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: counts enabled cycles and raises tick in the last
// cycle of each TICK_CYCLES-long period. Disabling freezes the count, so a
// paused period resumes with whatever count remained.
module led_prescaler #(
  parameter int TICK_CYCLES = 12_500_000,
  parameter int CNT_W       = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // tick is qualified by en so dropping en in the terminal cycle skips the step.
  assign tick = en && (cnt == LAST);

  // Period counter: wraps to zero on tick, holds while disabled.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_chaser.sv
// Parametrised LED sequencer: one-hot LED drive stepping on a programmable
// tick in rotate-up, rotate-down, ping-pong or hold mode.
// Optional build macro LED_CHASER_PWM_EN adds a duty input and an 8-bit
// free-running PWM counter that gates the lit LED.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int NUM_LEDS    = 4,
  parameter int TICK_CYCLES = 12_500_000,
  parameter int CNT_W       = 25,
  parameter int IDX_W       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
`ifdef LED_CHASER_PWM_EN
  input  logic [7:0]          duty,
`endif
  output logic [NUM_LEDS-1:0] led,
  output logic [IDX_W-1:0]    led_idx,
  output logic                step_pulse
);

  localparam logic [IDX_W-1:0]    IDX_ZERO = '0;
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

  logic             tick;
  logic             dir;
  logic             nxt_dir;
  logic [IDX_W-1:0] nxt_idx;
  logic [NUM_LEDS-1:0] onehot;

  led_prescaler #(
    .TICK_CYCLES (TICK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Next index/direction for the current mode; only consumed on a tick, so
  // mode is effectively sampled in tick cycles only.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    nxt_idx = led_idx;
    nxt_dir = dir;
    case (mode)
      MODE_ROT_UP: begin
        nxt_idx = (led_idx == IDX_LAST) ? IDX_ZERO : led_idx + IDX_ONE;
        nxt_dir = DIR_UP;
      end
      MODE_ROT_DN: begin
        nxt_idx = (led_idx == IDX_ZERO) ? IDX_LAST : led_idx - IDX_ONE;
        nxt_dir = DIR_DN;
      end
      MODE_PINGPONG: begin
        if (dir == DIR_UP) begin
          if (led_idx == IDX_LAST) begin
            nxt_idx = led_idx - IDX_ONE;
            nxt_dir = DIR_DN;
          end else begin
            nxt_idx = led_idx + IDX_ONE;
          end
        end else begin
          if (led_idx == IDX_ZERO) begin
            nxt_idx = IDX_ONE;
            nxt_dir = DIR_UP;
          end else begin
            nxt_idx = led_idx - IDX_ONE;
          end
        end
      end
      default: ;
    endcase
    // A single LED has nowhere to move; pin the index so it stays in range.
    if (NUM_LEDS == 1) nxt_idx = IDX_ZERO;
  end

  // Index, direction and step strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_idx    <= IDX_ZERO;
      dir        <= DIR_UP;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= tick && (mode != MODE_HOLD);
      if (tick) begin
        led_idx <= nxt_idx;
        dir     <= nxt_dir;
      end
    end
  end

  // One-hot decode straight from the index register.
  assign onehot = LED_ONE << led_idx;

`ifdef LED_CHASER_PWM_EN
  logic [7:0] pwm_cnt;

  // Free-running PWM phase counter, independent of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_cnt <= 8'd0;
    else      pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign led = onehot & {NUM_LEDS{pwm_cnt < duty}};
`else
  assign led = onehot;
`endif

endmodule

// File: tb/tb_led_chaser.sv
// Directed self-checking bench for led_chaser (TICK_CYCLES=4) with a 4-LED
// instance and a 1-LED instance sharing clock, reset and controls.
module tb_led_chaser;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       en   = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] duty = 8'd255;

  logic [3:0] a_led;
  logic [1:0] a_idx;
  logic       a_sp;
  logic [0:0] b_led;
  logic [0:0] b_idx;
  logic       b_sp;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  led_chaser #(.NUM_LEDS(4), .TICK_CYCLES(4), .CNT_W(2), .IDX_W(2)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
`ifdef LED_CHASER_PWM_EN
    .duty       (duty),
`endif
    .led        (a_led),
    .led_idx    (a_idx),
    .step_pulse (a_sp)
  );

  led_chaser #(.NUM_LEDS(1), .TICK_CYCLES(4), .CNT_W(2), .IDX_W(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
`ifdef LED_CHASER_PWM_EN
    .duty       (duty),
`endif
    .led        (b_led),
    .led_idx    (b_idx),
    .step_pulse (b_sp)
  );

`ifdef LED_CHASER_PWM_EN
  logic [7:0] pwm_model;
  always @(posedge clk or negedge rst) begin
    if (!rst) pwm_model <= 8'd0;
    else      pwm_model <= pwm_model + 8'd1;
  end
`endif

  // Expected LED vector for a lit index, including PWM gating when built in.
  function automatic logic [3:0] exp_led(input int idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
`ifdef LED_CHASER_PWM_EN
    if (!(pwm_model < duty)) v = 4'b0000;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int pp_exp [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int up_exp [4] = '{2, 3, 0, 1};
  logic hold_sp;
`ifdef LED_CHASER_PWM_EN
  int lit;
  int pulses;
  logic dark;
`endif

  initial begin
    // Reset state
    cyc(3);
    check("rst_led",  a_led, exp_led(0));
    check("rst_idx",  a_idx, 0);
    check("rst_sp",   a_sp,  0);
    check("rst_b_idx", b_idx, 0);

    // Release reset; first step 4 cycles later
    rst = 1'b1;
    en  = 1'b1;
    cyc(3);
    check("first_sp_early", a_sp, 0);
    check("first_idx_early", a_idx, 0);
    cyc(1);
    check("first_sp", a_sp, 1);
    check("first_idx", a_idx, 1);
    check("first_led", a_led, exp_led(1));
    check("b_first_sp", b_sp, 1);
    check("b_first_idx", b_idx, 0);

    // Rotate-up with wrap: one pulse per 4 cycles
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("up_sp_gap", a_sp, 0);
      cyc(3);
      check("up_sp", a_sp, 1);
      check("up_led", a_led, exp_led(up_exp[i]));
    end

    // Async reset mid-period with led=0100
    cyc(4);
    check("pre_rst_led", a_led, exp_led(2));
    cyc(2);
    rst = 1'b0;
    #2;
    check("async_led", a_led, exp_led(0));
    check("async_idx", a_idx, 0);
    check("async_sp", a_sp, 0);
    cyc(1);
    rst = 1'b1;
    cyc(3);
    check("rel_sp_early", a_sp, 0);
    cyc(1);
    check("rel_sp", a_sp, 1);
    check("rel_idx", a_idx, 1);

    // en=0 for 10 cycles mid-period; period resumes with the remaining 2 cycles
    cyc(2);
    en = 1'b0;
    cyc(10);
    check("frz_idx", a_idx, 1);
    check("frz_sp", a_sp, 0);
    en = 1'b1;
    cyc(1);
    check("resume_sp_early", a_sp, 0);
    cyc(1);
    check("resume_sp", a_sp, 1);
    check("resume_idx", a_idx, 2);

    // Mode switch one cycle after a tick: rot-up at idx 2 -> rot-down gives idx 1
    cyc(1);
    mode = 2'b01;
    cyc(3);
    check("sw_idx", a_idx, 1);
    check("sw_sp", a_sp, 1);

    // Ping-pong resumes heading down
    mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      cyc(4);
      check("pp_idx", a_idx, pp_exp[i]);
      check("pp_led", a_led, exp_led(pp_exp[i]));
      check("pp_sp", a_sp, 1);
      check("pp_b_idx", b_idx, 0);
      check("pp_b_sp", b_sp, 1);
    end

    // Hold: no steps, no pulses, prescaler keeps running
    mode = 2'b11;
    hold_sp = 1'b0;
    repeat (10) begin
      cyc(1);
      hold_sp = hold_sp | a_sp | b_sp;
    end
    check("hold_sp", hold_sp, 0);
    check("hold_idx", a_idx, 1);
    mode = 2'b00;
    cyc(1);
    check("unhold_sp_early", a_sp, 0);
    cyc(1);
    check("unhold_sp", a_sp, 1);
    check("unhold_idx", a_idx, 2);

    // en dropped in the tick cycle suppresses that step
    cyc(3);
    en = 1'b0;
    cyc(2);
    check("drop_idx", a_idx, 2);
    check("drop_sp", a_sp, 0);
    en = 1'b1;
    cyc(1);
    check("drop_resume_idx", a_idx, 3);
    check("drop_resume_sp", a_sp, 1);

`ifdef LED_CHASER_PWM_EN
    // duty=64: lit exactly 64 of any 256 consecutive cycles
    duty = 8'd64;
    lit = 0;
    repeat (256) begin
      cyc(1);
      if (|a_led) lit++;
    end
    check("pwm_64", lit, 64);

    // duty=0: all dark while the index keeps stepping
    duty = 8'd0;
    dark = 1'b1;
    pulses = 0;
    repeat (64) begin
      cyc(1);
      if (a_led != 4'b0000) dark = 1'b0;
      if (a_sp) pulses++;
    end
    check("pwm_dark", dark, 1);
    check("pwm_steps", pulses, 16);
    duty = 8'd255;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
